// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side (drives hazard inputs); slave: the controller.
interface hazard_ctrl_if;
  logic        idex_mem_read;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        ifid_rs1_used;
  logic        ifid_rs2_used;
  logic        branch_taken;
  logic        dmem_busy;
  logic        halt_req;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_write;
  logic        idex_bubble;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] freeze_cnt;

  modport master (
    output idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
           branch_taken, dmem_busy, halt_req,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, halted, state,
           stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
           branch_taken, dmem_busy, halt_req,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, halted, state,
           stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze / branch flush / load-use stall / halt drain.
// Define HAZARD_PERF_CNT_EN to build the stall/flush/freeze performance counters.
module hazard_ctrl (
  input logic          clk,
  input logic          reset_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] drain_q, drain_d;

  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;

  assign load_use = hz.idex_mem_read && (hz.idex_rd != 5'd0) &&
                    ((hz.ifid_rs1_used && (hz.ifid_rs1 == hz.idex_rd)) ||
                     (hz.ifid_rs2_used && (hz.ifid_rs2 == hz.idex_rd)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b1;

    unique case (state_q)
      RUN: begin
        if (hz.dmem_busy) begin
          idex_write  = 1'b0;
          idex_bubble = 1'b0;
        end else if (hz.branch_taken) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end else if (load_use) begin
          idex_bubble = 1'b1;
        end else if (hz.halt_req) begin
          state_d = DRAIN;
          drain_d = 2'd3;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_bubble = 1'b0;
        end
      end
      DRAIN: begin
        if (hz.dmem_busy) begin
          idex_write  = 1'b0;
          idex_bubble = 1'b0;
        end else begin
          drain_d = drain_q - 2'd1;
          if (drain_q <= 2'd1) state_d = HALTED;
        end
      end
      HALTED: begin
        idex_write = 1'b0;
      end
      default: begin
        state_d = RUN;
        drain_d = '0;
      end
    endcase

    // Outputs follow reset_n directly so the pipeline is held safe before any edge.
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_write  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_write  = idex_write;
  assign hz.idex_bubble = idex_bubble;
  assign hz.halted      = (state_q == HALTED);
  assign hz.state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic        stall_ev, flush_ev, freeze_ev;
  logic [31:0] stall_q, flush_q, freeze_q;

  assign flush_ev  = (state_q == RUN) && !hz.dmem_busy && hz.branch_taken;
  assign stall_ev  = (state_q == RUN) && !hz.dmem_busy && !hz.branch_taken && load_use;
  assign freeze_ev = (state_q != HALTED) && hz.dmem_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (stall_ev)  stall_q  <= stall_q + 32'd1;
      if (flush_ev)  flush_q  <= flush_q + 32'd1;
      if (freeze_ev) freeze_q <= freeze_q + 32'd1;
    end
  end

  assign hz.stall_cnt  = stall_q;
  assign hz.flush_cnt  = flush_q;
  assign hz.freeze_cnt = freeze_q;
`else
  assign hz.stall_cnt  = '0;
  assign hz.flush_cnt  = '0;
  assign hz.freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic clk;
  logic reset_n;

  hazard_ctrl_if hif ();

  hazard_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}
  localparam logic [4:0] PASS   = 5'b11010;
  localparam logic [4:0] STALL  = 5'b00011;
  localparam logic [4:0] FLUSH  = 5'b11111;
  localparam logic [4:0] FREEZE = 5'b00000;
  localparam logic [4:0] DRN    = 5'b00011;
  localparam logic [4:0] HLT    = 5'b00001;
  localparam logic [4:0] RST    = 5'b00111;
  localparam logic [1:0] S_RUN = 2'b00, S_DRAIN = 2'b01, S_HALT = 2'b10;

  typedef struct {
    string       name;
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic        hlt;
    logic [31:0] s, f, z;
  } exp_t;

  exp_t sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic step(input string nm, input logic rst,
                      input logic mr, input logic [4:0] rd, rs1, rs2,
                      input logic u1, u2, br, busy, halt,
                      input logic [4:0] ctl, input logic [1:0] st,
                      input int unsigned s, f, z);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n           = rst;
    hif.idex_mem_read = mr;
    hif.idex_rd       = rd;
    hif.ifid_rs1      = rs1;
    hif.ifid_rs2      = rs2;
    hif.ifid_rs1_used = u1;
    hif.ifid_rs2_used = u2;
    hif.branch_taken  = br;
    hif.dmem_busy     = busy;
    hif.halt_req      = halt;
    e.name = nm;
    e.ctl  = ctl;
    e.st   = st;
    e.hlt  = (st == S_HALT);
`ifdef HAZARD_PERF_CNT_EN
    e.s = s; e.f = f; e.z = z;
`else
    e.s = 0; e.f = 0; e.z = 0;
`endif
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [4:0] got;
      e   = sb.pop_front();
      got = {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_write, hif.idex_bubble};
      total++;
      if (got === e.ctl) passed++;
      else $display("FAIL %s ctl got %b want %b", e.name, got, e.ctl);
      total++;
      if (hif.state === e.st && hif.halted === e.hlt) passed++;
      else $display("FAIL %s state/halted got %b/%b want %b/%b",
                    e.name, hif.state, hif.halted, e.st, e.hlt);
      total++;
      if (hif.stall_cnt === e.s && hif.flush_cnt === e.f && hif.freeze_cnt === e.z) passed++;
      else $display("FAIL %s cnt got %0d/%0d/%0d want %0d/%0d/%0d", e.name,
                    hif.stall_cnt, hif.flush_cnt, hif.freeze_cnt, e.s, e.f, e.z);
    end
  end

  initial begin
    reset_n = 1'b0;
    hif.idex_mem_read = 1'b0; hif.idex_rd = '0; hif.ifid_rs1 = '0; hif.ifid_rs2 = '0;
    hif.ifid_rs1_used = 1'b0; hif.ifid_rs2_used = 1'b0; hif.branch_taken = 1'b0;
    hif.dmem_busy = 1'b0; hif.halt_req = 1'b0;

    //     name        rst mr rd rs1 rs2 u1 u2 br bz ht  ctl     state    s f z
    step("reset",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,    S_RUN,   0, 0, 0);
    step("pass0",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS,   S_RUN,   0, 0, 0);
    step("lu_rs1",     1, 1, 5, 5, 0, 1, 0, 0, 0, 0, STALL,  S_RUN,   0, 0, 0);
    step("after_lu",   1, 0, 0, 5, 0, 1, 0, 0, 0, 0, PASS,   S_RUN,   1, 0, 0);
    step("lu_rs2",     1, 1, 7, 3, 7, 1, 1, 0, 0, 0, STALL,  S_RUN,   1, 0, 0);
    step("rs2_unused", 1, 1, 7, 3, 7, 1, 0, 0, 0, 0, PASS,   S_RUN,   2, 0, 0);
    step("x0",         1, 1, 0, 0, 0, 1, 1, 0, 0, 0, PASS,   S_RUN,   2, 0, 0);
    step("lu_br",      1, 1, 5, 5, 0, 1, 0, 1, 0, 0, FLUSH,  S_RUN,   2, 0, 0);
    step("pass1",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS,   S_RUN,   2, 1, 0);
    step("frz_all",    1, 1, 5, 5, 0, 1, 0, 1, 1, 1, FREEZE, S_RUN,   2, 1, 0);
    step("pass2",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS,   S_RUN,   2, 1, 1);
    step("br_halt",    1, 0, 0, 0, 0, 0, 0, 1, 0, 1, FLUSH,  S_RUN,   2, 1, 1);
    step("lu_halt",    1, 1, 5, 5, 0, 1, 0, 0, 0, 1, STALL,  S_RUN,   2, 2, 1);
    step("halt",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, DRN,    S_RUN,   3, 2, 1);
    step("drn_frz1",   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, FREEZE, S_DRAIN, 3, 2, 1);
    step("drn_frz2",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE, S_DRAIN, 3, 2, 2);
    step("drn_br",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, DRN,    S_DRAIN, 3, 2, 3);
    step("drn_lu",     1, 1, 5, 5, 0, 1, 0, 0, 0, 0, DRN,    S_DRAIN, 3, 2, 3);
    step("drn_last",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DRN,    S_DRAIN, 3, 2, 3);
    step("halted_bz",  1, 0, 0, 0, 0, 0, 0, 1, 1, 0, HLT,    S_HALT,  3, 2, 3);
    step("halted",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, HLT,    S_HALT,  3, 2, 3);
    step("rst_halted", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,    S_RUN,   0, 0, 0);
    step("post_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS,   S_RUN,   0, 0, 0);
    step("halt2",      1, 0, 0, 0, 0, 0, 0, 0, 0, 1, DRN,    S_RUN,   0, 0, 0);
    step("drain2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DRN,    S_DRAIN, 0, 0, 0);
    step("rst_drain",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,    S_RUN,   0, 0, 0);
    step("run_again",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS,   S_RUN,   0, 0, 0);
    step("lu_again",   1, 1, 9, 0, 9, 0, 1, 0, 0, 0, STALL,  S_RUN,   0, 0, 0);
    step("pass_end",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS,   S_RUN,   1, 0, 0);

    repeat (3) @(posedge clk);
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain scoreboard left %0d want 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
